// File: rtl/tsu_rdout_if.sv
// Bundles the TSU queue read port and the host register bus of tsu_rdout.
// The slave modport is the read-out block; the master modport is the queue/host side.
interface tsu_rdout_if;
    logic        q_rd_en;
    logic [7:0]  q_rd_stat;
    logic [47:0] q_rd_data;
    logic        q_rst;
    logic        bus_cs;
    logic        bus_rd;
    logic        bus_wr;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;

    modport slave (
        output q_rd_en,
        input  q_rd_stat,
        input  q_rd_data,
        output q_rst,
        input  bus_cs,
        input  bus_rd,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output irq
    );

    modport master (
        input  q_rd_en,
        output q_rd_stat,
        output q_rd_data,
        input  q_rst,
        output bus_cs,
        output bus_rd,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  irq
    );
endinterface

// File: rtl/tsu_rdout.sv
// Pops 48-bit time stamps from the TSU queue into a single capture register and exposes them to the host.
// Define TSU_RDOUT_IRQ_EN to implement the entry-available interrupt and its CTRL enable bit.
module tsu_rdout #(
    parameter int POP_CNT_W = 16,
    parameter int FLUSH_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    tsu_rdout_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_CAPT,
        S_HELD,
        S_FLUSH
    } state_t;

    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_t                r_state;
    logic                  r_q_rd_en;
    logic                  r_q_rst;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [47:0]           r_hold;
    logic                  r_hold_valid;
    logic [POP_CNT_W-1:0]  r_pop_cnt;
    logic                  r_auto_en;
    logic [3:0]            r_stat_q;
    logic [31:0]           r_rdata;

    logic                  w_rd;
    logic                  w_wr_ctrl;
    logic                  w_flush_req;
    logic                  w_ts_lo_rd;
    logic                  w_irq_en;
    logic [15:0]           w_pop_cnt16;
    logic [31:0]           w_rd_mux;

    assign w_rd        = bus.bus_cs & bus.bus_rd;
    assign w_wr_ctrl   = bus.bus_cs & bus.bus_wr & (bus.bus_addr == 2'd0);
    assign w_flush_req = w_wr_ctrl & bus.bus_wdata[2];
    assign w_ts_lo_rd  = w_rd & (bus.bus_addr == 2'd3);
    assign w_pop_cnt16 = 16'(r_pop_cnt);

    // Upper status bits and the unmapped write-data bits carry no function here.
    wire w_unused_bits = ^{bus.q_rd_stat[7:4], bus.bus_wdata[31:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_auto_en <= bus.bus_wdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_q <= 4'd0;
        end else begin
            r_stat_q <= bus.q_rd_stat[3:0];
        end
    end

    // A flush write overrides every state, including a concurrent TS_LO consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_q_rd_en    <= 1'b0;
            r_q_rst      <= 1'b0;
            r_flush_cnt  <= '0;
            r_hold       <= 48'd0;
            r_hold_valid <= 1'b0;
            r_pop_cnt    <= '0;
        end else begin
            r_q_rd_en <= 1'b0;
            if (w_flush_req) begin
                r_state      <= S_FLUSH;
                r_q_rst      <= 1'b1;
                r_flush_cnt  <= FC_W'(FLUSH_CYC - 1);
                r_hold_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_auto_en && (r_stat_q != 4'd0)) begin
                            r_state   <= S_POP;
                            r_q_rd_en <= 1'b1;
                        end
                    end
                    S_POP: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_state <= S_CAPT;
                    end
                    S_CAPT: begin
                        r_hold       <= bus.q_rd_data;
                        r_hold_valid <= 1'b1;
                        r_pop_cnt    <= r_pop_cnt + POP_CNT_W'(1);
                        r_state      <= S_HELD;
                    end
                    S_HELD: begin
                        if (w_ts_lo_rd) begin
                            r_hold_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                    S_FLUSH: begin
                        if (r_flush_cnt == '0) begin
                            r_q_rst <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - FC_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TSU_RDOUT_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irq_en <= bus.bus_wdata[1];
            end
            r_irq <= r_hold_valid & r_irq_en;
        end
    end

    assign w_irq_en = r_irq_en;
    assign bus.irq  = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign bus.irq  = 1'b0;
`endif

    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.bus_addr)
            2'd0: w_rd_mux = {29'd0, 1'b0, w_irq_en, r_auto_en};
            2'd1: w_rd_mux = {w_pop_cnt16, 6'd0, (r_state == S_FLUSH), r_hold_valid, 4'd0, r_stat_q};
            2'd2: w_rd_mux = {16'd0, r_hold[47:32]};
            2'd3: w_rd_mux = r_hold[31:0];
            default: w_rd_mux = 32'd0;
        endcase
    end

    // Read data holds its last value between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
        end else if (w_rd) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign bus.q_rd_en   = r_q_rd_en;
    assign bus.q_rst     = r_q_rst;
    assign bus.bus_rdata = r_rdata;

endmodule

// File: tb/tb_tsu_rdout.sv
// Directed bench for tsu_rdout: models the TSU queue read port and plays host register accesses.
// Expected irq/CTRL values follow TSU_RDOUT_IRQ_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_tsu_rdout;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tsu_rdout_if u_if();

    tsu_rdout #(
        .POP_CNT_W (16),
        .FLUSH_CYC (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

`ifdef TSU_RDOUT_IRQ_EN
    localparam logic IRQ_EXP  = 1'b1;
    localparam logic [31:0] CTRL3_EXP = 32'h3;
`else
    localparam logic IRQ_EXP  = 1'b0;
    localparam logic [31:0] CTRL3_EXP = 32'h1;
`endif

    localparam logic [47:0] TD [0:9] = '{
        48'h1234_5678_9ABC, 48'hA0A1_B2B3_C4C5, 48'h0F0E_0D0C_0B0A,
        48'hFFFF_0000_FFFF, 48'h5555_AAAA_5555, 48'h0102_0304_0506,
        48'h7777_8888_9999, 48'hDEAD_BEEF_CAFE, 48'h4444_3333_2222,
        48'h1111_2222_3333
    };

    // Queue model: host side pushes, DUT pops; data registered the cycle after q_rd_en.
    logic [47:0] qmem [16];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    int          cyc = 0;
    int          pops = 0;
    int          last_pop = -1;
    int          min_gap = 1000;

    assign u_if.q_rd_stat = {4'h0, wr_ptr - rd_ptr};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (u_if.q_rst) begin
            rd_ptr <= wr_ptr;
        end else if (u_if.q_rd_en) begin
            u_if.q_rd_data <= qmem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
            pops <= pops + 1;
            if (last_pop >= 0 && (cyc - last_pop) < min_gap)
                min_gap <= cyc - last_pop;
            last_pop <= cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] d);
        qmem[wr_ptr] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        u_if.bus_cs = 1'b1;
        u_if.bus_wr = 1'b1;
        u_if.bus_addr = a;
        u_if.bus_wdata = d;
        @(posedge clk);
        #1;
        u_if.bus_cs = 1'b0;
        u_if.bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        u_if.bus_cs = 1'b1;
        u_if.bus_rd = 1'b1;
        u_if.bus_addr = a;
        @(posedge clk);
        #1;
        u_if.bus_cs = 1'b0;
        u_if.bus_rd = 1'b0;
        d = u_if.bus_rdata;
    endtask

    task automatic wait_hold(input string tag);
        logic [31:0] v;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_read(2'd1, v);
            if (v[8]) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic wait_pop(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (u_if.q_rd_en) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        check(tag, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [47:0] d;
        logic [5:0]  pat;
        int          pc;

        u_if.bus_cs = 1'b0;
        u_if.bus_rd = 1'b0;
        u_if.bus_wr = 1'b0;
        u_if.bus_addr = 2'd0;
        u_if.bus_wdata = 32'd0;

        // Reset state
        step(3);
        rst_n = 1'b1;
        step(1);
        check("rst_q_rd_en", u_if.q_rd_en, 0);
        check("rst_q_rst", u_if.q_rst, 0);
        check("rst_rdata", u_if.bus_rdata, 0);
        check("rst_irq", u_if.irq, 0);
        bus_read(2'd0, v);
        check("rst_ctrl", v, 0);
        bus_read(2'd1, v);
        check("rst_stat", v, 0);

        // Single entry, exact pop timing
        push(TD[0]);
        step(3);
        bus_write(2'd0, 32'h1);
        check("t1_rd_en_e0", u_if.q_rd_en, 0);
        step(1);
        check("t1_rd_en_e1", u_if.q_rd_en, 1);
        step(1);
        check("t1_rd_en_e2", u_if.q_rd_en, 0);
        step(1);
        bus_read(2'd1, v);
        check("t1_stat_pre", v, 32'h0000_0000);
        bus_read(2'd1, v);
        check("t1_stat_held", v, 32'h0001_0100);
        check("t1_irq_off", u_if.irq, 0);
        bus_read(2'd2, v);
        check("t1_ts_hi", v, 32'h0000_1234);
        bus_read(2'd3, v);
        check("t1_ts_lo", v, 32'h5678_9ABC);
        bus_read(2'd1, v);
        check("t1_stat_after", v, 32'h0001_0000);
        check("t1_pops", pops, 1);

        // Three entries, one held at a time
        push(TD[1]);
        push(TD[2]);
        push(TD[3]);
        for (int k = 0; k < 3; k++) begin
            wait_hold($sformatf("t2_hold%0d", k));
            pc = pops;
            step(6);
            check($sformatf("t2_nopop_held%0d", k), pops, pc);
            d = TD[1 + k];
            bus_read(2'd2, v);
            check($sformatf("t2_ts_hi%0d", k), v, {16'h0, d[47:32]});
            bus_read(2'd3, v);
            check($sformatf("t2_ts_lo%0d", k), v, d[31:0]);
        end
        step(10);
        check("t2_pops", pops, 4);
        check("t2_gap_ge4", (min_gap >= 4), 1);
        bus_read(2'd1, v);
        check("t2_stat", v, 32'h0004_0000);

        // Flush with an entry held
        push(TD[4]);
        push(TD[5]);
        wait_hold("t3_hold");
        bus_write(2'd0, 32'h5);
        pat = 6'd0;
        for (int i = 0; i < 6; i++) begin
            pat[i] = u_if.q_rst;
            step(1);
        end
        check("t3_q_rst_pattern", pat, 6'b00_1111);
        bus_read(2'd1, v);
        check("t3_stat", v, 32'h0005_0000);
        check("t3_pops", pops, 5);
        push(TD[6]);
        wait_hold("t3_resume_hold");
        d = TD[6];
        bus_read(2'd2, v);
        check("t3_ts_hi", v, {16'h0, d[47:32]});
        bus_read(2'd3, v);
        check("t3_ts_lo", v, d[31:0]);

        // Flush during WAIT discards the capture
        push(TD[7]);
        wait_pop("t4_pop");
        step(1);
        bus_write(2'd0, 32'h5);
        bus_read(2'd1, v);
        check("t4_stat_flushing", v, 32'h0006_0200);
        step(8);
        bus_read(2'd1, v);
        check("t4_stat_idle", v, 32'h0006_0000);
        bus_read(2'd3, v);
        check("t4_stale_lo", v, d[31:0]);
        bus_read(2'd1, v);
        check("t4_stat_stale", v, 32'h0006_0000);
        check("t4_pops", pops, 7);

        // Interrupt timing
        bus_write(2'd0, 32'h3);
        bus_read(2'd0, v);
        check("t5_ctrl", v, CTRL3_EXP);
        push(TD[8]);
        wait_pop("t5_pop");
        step(1);
        check("t5_irq_p1", u_if.irq, 0);
        step(2);
        check("t5_irq_p3", u_if.irq, 0);
        step(1);
        check("t5_irq_p4", u_if.irq, IRQ_EXP);
        d = TD[8];
        bus_read(2'd3, v);
        check("t5_ts_lo", v, d[31:0]);
        check("t5_irq_p5", u_if.irq, IRQ_EXP);
        step(1);
        check("t5_irq_p6", u_if.irq, 0);
        bus_read(2'd1, v);
        check("t5_stat", v, 32'h0007_0000);

        // Reset during POP
        push(TD[9]);
        wait_pop("t6_pop");
        rst_n = 1'b0;
        #1;
        check("t6_q_rd_en", u_if.q_rd_en, 0);
        check("t6_q_rst", u_if.q_rst, 0);
        check("t6_rdata", u_if.bus_rdata, 0);
        check("t6_irq", u_if.irq, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(10);
        check("t6_pops", pops, 8);
        bus_read(2'd0, v);
        check("t6_ctrl", v, 0);
        bus_read(2'd1, v);
        check("t6_stat", v, 32'h0000_0001);
        bus_read(2'd3, v);
        check("t6_ts_lo", v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tsu_rdout.md
# tsu_rdout

Read-side consumer of the time-stamp unit's PTP queue: pops 48-bit time-stamp entries from the queue read port, holds one entry in a capture register, and exposes it with queue status to the host through a simple 32-bit register interface. Sits in the `q_rd_clk` domain, between the TSU queue read port and the host bus decoder. It provides single-entry flow control (no new pop while an entry is unread), a software queue flush and an optional interrupt.

## Interface
- `POP_CNT_W`, 16: width of the wrapping popped-entry counter (≤16).
- `FLUSH_CYC`, 4: number of cycles `q_rst` is held high per flush.
- `clk`  in  1  queue read clock; the block's only clock, connected to `q_rd_clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `q_rd_en`  out  1  queue pop request, one cycle per entry.
- `q_rd_stat`  in  8  queue status; `[3:0]` is the used-word count.
- `q_rd_data`  in  48  queue head data, valid the cycle after `q_rd_en`.
- `q_rst`  out  1  queue asynchronous clear (flush).
- `bus_cs`, `bus_rd`, `bus_wr`  in  1  host access strobes; single-cycle.
- `bus_addr`  in  2  word address.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, registered.
- `irq`  out  1  level interrupt: entry available.

## Operation
- Register map:
  - 0 CTRL (rw): b0 `auto_en`, b1 `irq_en`, b2 `flush` (write-1 pulse, reads 0).
  - 1 STAT (ro): `[3:0]` registered `q_rd_stat[3:0]`, b8 `hold_valid`, b9 `flushing`, `[31:16]` pop count (zero-extended).
  - 2 TS_HI (ro): `{16'h0, hold[47:32]}`.
  - 3 TS_LO (ro): `hold[31:0]`. A read consumes the entry.
- Writes to ro registers are ignored.
- FSM states: IDLE, POP, WAIT, CAPT, HELD, FLUSH.
  - IDLE→POP when `auto_en` and `stat_q[3:0]≥1` and not flushing. POP drives `q_rd_en=1` for exactly one cycle.
  - POP→WAIT→CAPT.
  - CAPT: latch `q_rd_data` into `hold`, set `hold_valid`, increment pop count (wraps all-ones→0), then go to HELD.
  - HELD→IDLE on an accepted TS_LO read (`bus_cs&bus_rd&bus_addr==3`). The read returns the held data and clears `hold_valid` in the same cycle.
- TS_LO read with `hold_valid=0` returns the stale `hold` and has no side effect. TS_HI reads never have side effects; software reads HI then LO.
- Flush: write CTRL b2=1.
  - From any state, go to FLUSH. `q_rst` goes high for `FLUSH_CYC` cycles, `hold_valid` clears, any pending capture is discarded, then return to IDLE.
  - The pop count is not cleared.
  - A TS_LO read in the same cycle as a flush write returns data, but the flush wins the state.
- Clearing `auto_en` while the FSM is in POP, WAIT or CAPT completes the current entry. No new pop is issued.
- `bus_cs` low: no access and no side effects. Unmapped bits read 0.

## Timing
- Reset values:
  - `q_rd_en=0`, `q_rst=0`, `bus_rdata=0`, `irq=0`.
  - CTRL=0, `hold=0`, `hold_valid=0`, pop count=0, `stat_q=0`, state IDLE.
- `q_rd_stat` is registered once (`stat_q`) before FSM use.
- Minimum pop spacing is 4 cycles: POP, WAIT, CAPT, plus at least one cycle in HELD/IDLE. This guarantees `q_rd_stat` reflects the previous pop before the next decision.
- `bus_rdata` is valid 1 cycle after the accepted read. When no read is active, the last value is held.
- Write effects are visible 1 cycle after the write strobe.
- `hold_valid` rises 3 cycles after `q_rd_en` and falls the cycle after the TS_LO read strobe.
- `irq` is registered and follows `hold_valid & irq_en` with a 1-cycle lag.
- Reset asserted mid-operation aborts immediately. `q_rd_en` and `q_rst` drop asynchronously, and any popped entry is lost.

## Configuration
- `TSU_RDOUT_IRQ_EN` defined: `irq` logic and CTRL b1 are implemented as above.
- Undefined:
  - `irq` is tied to 0.
  - CTRL b1 is not stored and reads 0; writes to it are ignored.
  - All other behaviour is identical.

## Test plan
- Queue count 1, `auto_en=1`, data `48'h1234_5678_9ABC`:
  - Exactly one `q_rd_en` pulse.
  - `hold_valid` set 3 cycles later.
  - TS_HI=`0x00001234`, TS_LO=`0x56789ABC`.
  - Pop count=1.
- Queue count 3, host reads TS_LO each time `hold_valid` is set:
  - Three pops total, each spaced ≥4 cycles.
  - No second pop occurs while `hold_valid=1`.
- Entry held, write CTRL `0x5`:
  - `q_rst` high exactly 4 cycles.
  - `hold_valid=0`.
  - Pop count unchanged.
  - Pops resume after the flush.
- Flush written during WAIT:
  - No capture occurs.
  - FLUSH, then IDLE.
  - Pop count does not increment.
- With `TSU_RDOUT_IRQ_EN`: `irq_en=1`, entry captured:
  - `irq` rises 1 cycle after `hold_valid`.
  - `irq` falls after the TS_LO read.
  - Without the macro: `irq` stays 0 and CTRL reads `0x1`.
- `rst_n` low during POP:
  - All outputs go to reset values immediately.
  - After release, the FSM is in IDLE with `auto_en=0` and issues no pops.
